apb_cmd_master: RTL and testbench

- Upstream APB requester for the counter APB slave and its peers.
- Converts a simple valid/ready command interface (from a CPU/test sequencer) into one APB3 transfer at a time: SETUP phase, then ACCESS phase.
- Returns read data and a completion pulse to the requester.
- PSEL, PENABLE, PWRITE, PADDR and PWDATA connect directly to the slave's pins of the same name.

---
 rtl/apb_cmd_master.sv | 144 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command port into one APB3 SETUP/ACCESS transfer at a time.
// Optional ACCESS wait timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_cmd_ready;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_rsp_err;
    logic             w_timeout;

    assign w_timeout = (r_wait_cnt == CNT_LAST);
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

    // cmd_ready is its own register so it stays low for the first cycle after reset release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            r_wait_cnt  <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_state     <= S_SETUP;
                        r_cmd_ready <= 1'b0;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_pwrite    <= cmd_write;
                        r_paddr     <= cmd_addr;
                        r_pwdata    <= cmd_wdata;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_state    <= S_ACCESS;
                    r_penable  <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_state     <= S_IDLE;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        if (!r_pwrite) begin
                            r_rsp_rdata <= PRDATA;
                        end
`ifdef APB_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                    end
`ifdef APB_TIMEOUT_EN
                    // PREADY in the last allowed cycle takes priority over the abort
                    else if (w_timeout) begin
                        r_state     <= S_IDLE;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: command driver, reactive APB slave model, response monitor.
module tb_apb_cmd_master;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int TO     = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA = '0;
    logic              PREADY = 1'b0;

    always #5 clk = ~clk;

    apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    typedef struct {
        bit                write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                waits;
        logic [DATA_W-1:0] rdata;
    } plan_t;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        bit                err;
        int                en_cycles;
    } rsp_t;

    plan_t             plan_q[$];
    rsp_t              exp_q[$];
    int                checks = 0;
    int                failures = 0;
    logic [DATA_W-1:0] model_rdata = '0;
    bit                stray_mode = 1'b0;

    plan_t cur;
    int    wcnt = 0;
    int    en_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or event missing at %0t", name, $time);
    endtask

    // Reference: each command yields exactly one response, computed from the transfer rules.
    task automatic send(input bit write, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        input int waits, input logic [DATA_W-1:0] rdata, input bit hold,
                        output bit acc_with_rsp);
        plan_t p;
        rsp_t  r;
        int    n;
        p.write = write; p.addr = addr; p.wdata = wdata; p.waits = waits; p.rdata = rdata;
        r.err = 1'b0;
        r.rdata = write ? model_rdata : rdata;
        r.en_cycles = waits + 1;
`ifdef APB_TIMEOUT_EN
        if (waits >= TO) begin
            r.err = 1'b1;
            r.rdata = '0;
            r.en_cycles = TO;
        end
`endif
        model_rdata = r.rdata;
        plan_q.push_back(p);
        exp_q.push_back(r);
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("cmd_accept");
        acc_with_rsp = rsp_valid;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || PSEL !== 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("wait_idle");
    endtask

    // APB slave: pops a plan at SETUP, inserts the planned wait states, scribbles outside ACCESS.
    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            PREADY = 1'b0;
            PRDATA = '0;
        end else if (PSEL && !PENABLE) begin
            if (plan_q.size() == 0) begin
                fail_now("unplanned_setup");
            end else begin
                cur = plan_q.pop_front();
            end
            wcnt = 0;
            en_cnt = 0;
            check("setup_paddr", 32'(PADDR), 32'(cur.addr));
            check_bit("setup_pwrite", PWRITE, cur.write);
            check("setup_pwdata", PWDATA, cur.wdata);
            PREADY = 1'($urandom_range(0, 1));
            PRDATA = $urandom;
        end else if (PSEL && PENABLE) begin
            en_cnt++;
            check("access_paddr", 32'(PADDR), 32'(cur.addr));
            check_bit("access_pwrite", PWRITE, cur.write);
            check("access_pwdata", PWDATA, cur.wdata);
            if (wcnt == cur.waits) begin
                PREADY = 1'b1;
                PRDATA = cur.write ? $urandom : cur.rdata;
            end else begin
                PREADY = 1'b0;
                PRDATA = $urandom;
                wcnt++;
            end
        end else if (stray_mode) begin
            PREADY = ~PREADY;
            PRDATA = 32'hDEAD_BEEF;
        end else begin
            PREADY = 1'($urandom_range(0, 1));
            PRDATA = $urandom;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (PSEL) check_bit("cmd_ready_busy", cmd_ready, 1'b0);
            if (PENABLE) check_bit("penable_without_psel", PSEL, 1'b1);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check_bit("rsp_err", rsp_err, e.err);
                    check("penable_cycles", 32'(en_cnt), 32'(e.en_cycles));
                    check_bit("rsp_cycle_idle", PSEL, 1'b0);
                end
            end
        end
    end

    initial begin
        bit acc;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("rst_cmd_ready", cmd_ready, 1'b0);
        check_bit("rst_psel", PSEL, 1'b0);
        check_bit("rst_penable", PENABLE, 1'b0);
        check_bit("rst_rsp_valid", rsp_valid, 1'b0);
        check_bit("rst_rsp_err", rsp_err, 1'b0);
        check_bit("rst_pwrite", PWRITE, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_paddr", 32'(PADDR), 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        rstn = 1'b1;
        #1 check_bit("ready_before_first_clk", cmd_ready, 1'b0);
        @(negedge clk);
        check_bit("ready_after_first_clk", cmd_ready, 1'b1);

        send(1'b1, 4'd0, 32'h0000_0010, 0, 32'h0, 1'b0, acc);
        check_bit("wr_c1_psel", PSEL, 1'b1);
        check_bit("wr_c1_penable", PENABLE, 1'b0);
        check("wr_c1_paddr", 32'(PADDR), 32'h0);
        check("wr_c1_pwdata", PWDATA, 32'h10);
        check_bit("wr_c1_pwrite", PWRITE, 1'b1);
        @(negedge clk);
        check_bit("wr_c2_psel", PSEL, 1'b1);
        check_bit("wr_c2_penable", PENABLE, 1'b1);
        @(negedge clk);
        check_bit("wr_c3_rsp_valid", rsp_valid, 1'b1);
        check_bit("wr_c3_rsp_err", rsp_err, 1'b0);
        wait_idle();

        send(1'b0, 4'd3, $urandom, 2, 32'h0000_0025, 1'b0, acc);
        wait_idle();
        check("rd_wait_rdata_held", rsp_rdata, 32'h25);

        send(1'b1, 4'd1, 32'h1, 0, 32'h0, 1'b1, acc);
        send(1'b0, 4'd0, 32'h0, 1, $urandom, 1'b0, acc);
        check_bit("b2b_accept_in_rsp_cycle", acc, 1'b1);
        wait_idle();

        stray_mode = 1'b1;
        repeat (8) @(negedge clk);
        stray_mode = 1'b0;
        check("stray_rdata_unchanged", rsp_rdata, model_rdata);
        check_bit("stray_still_idle", PSEL, 1'b0);

`ifdef APB_TIMEOUT_EN
        send(1'b0, 4'd2, 32'h0, TO + 3, $urandom, 1'b0, acc);
        wait_idle();
        check("timeout_rdata", rsp_rdata, 32'h0);
        check_bit("timeout_back_to_idle", cmd_ready, 1'b1);
`endif

        send(1'b0, 4'd2, 32'h0, 100000, $urandom, 1'b0, acc);
        @(negedge clk);
`ifndef APB_TIMEOUT_EN
        repeat (100) @(negedge clk);
        check_bit("hang_still_psel", PSEL, 1'b1);
`endif
        check_bit("in_access_before_reset", PENABLE, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check_bit("midrst_psel", PSEL, 1'b0);
        check_bit("midrst_penable", PENABLE, 1'b0);
        check_bit("midrst_cmd_ready", cmd_ready, 1'b0);
        plan_q.delete();
        exp_q.delete();
        model_rdata = '0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_rdata", rsp_rdata, 32'h0);
        send(1'b0, 4'd3, 32'h0, 1, 32'hA5A5_0001, 1'b0, acc);
        wait_idle();
        check("post_rst_read", rsp_rdata, 32'hA5A5_0001);

        for (int i = 0; i < 60; i++) begin
            bit h;
            int w;
`ifdef APB_TIMEOUT_EN
            w = $urandom_range(0, TO + 1);
`else
            w = $urandom_range(0, 3);
`endif
            h = 1'($urandom_range(0, 1));
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, w, $urandom, h, acc);
            if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_idle();
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("plan_q_drained", 32'(plan_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation did not finish at %0t", $time);
        $fatal(1);
    end

endmodule
